// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
// Optional write-first bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 12;
  localparam int REGFILE_DEPTH  = 8;
  localparam int REGFILE_N_READ = 2;

  function automatic int field_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write/read bus of the register file.
// master drives requests; slave returns registered read data.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = $clog2(REGFILE_DEPTH),
  parameter int N_READ = REGFILE_N_READ
) ();

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [N_READ-1:0]        rd_en;
  logic [N_READ*ADDR_W-1:0] raddr;
  logic [N_READ*DATA_W-1:0] rdata;
  logic [N_READ-1:0]        rd_valid;

  modport master (
    output we, waddr, wdata, rd_en, raddr,
    input  rdata, rd_valid
  );

  modport slave (
    input  we, waddr, wdata, rd_en, raddr,
    output rdata, rd_valid
  );

endinterface

// File: rtl/regfile_read_port.sv
// One synchronous read port: range/zero checks, optional bypass,
// registered data and valid. Bypass compare exists only with REGFILE_BYPASS_EN.
module regfile_read_port #(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic              we_eff,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid
);

  logic              in_range;
  logic              is_zero;
  logic [DATA_W-1:0] sel;

  assign in_range = int'(raddr) < DEPTH;
  assign is_zero  = (ZERO_REG != 0) && (raddr == '0);

  // Pick the value this port would return at the next edge.
  always_comb begin
    sel = '0;
    if (in_range && !is_zero) begin
      sel = mem[raddr];
`ifdef REGFILE_BYPASS_EN
      if (we_eff && (waddr == raddr))
        sel = wdata;
`endif
    end
  end

  // Output registers; data holds while the port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rdata <= sel;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file with N_READ one-cycle read ports and one write port.
// Define REGFILE_BYPASS_EN for write-first; default is read-first.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int N_READ   = REGFILE_N_READ,
  parameter int ZERO_REG = 0
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we_eff;
  logic [DATA_W-1:0] rq [N_READ];
  logic [N_READ-1:0] vq;

  assign we_eff = bus.we
               && (int'(bus.waddr) < DEPTH)
               && !((ZERO_REG != 0) && (bus.waddr == '0));

  // Storage: cleared by reset, written when the write is effective.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++)
        mem[j] <= '0;
    end else if (we_eff) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (bus.rd_en[i]),
      .raddr    (bus.raddr[field_lo(i, ADDR_W) +: ADDR_W]),
      .mem      (mem),
`ifdef REGFILE_BYPASS_EN
      .we_eff   (we_eff),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
`endif
      .rdata    (rq[i]),
      .rd_valid (vq[i])
    );
  end

  // Pack per-port registers onto the bus.
  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < N_READ; k++)
      bus.rdata[field_lo(k, DATA_W) +: DATA_W] = rq[k];
  end

  assign bus.rd_valid = vq;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with a scoreboard queue.
// dut_a: DEPTH 8, no zero reg. dut_b: DEPTH 6, ZERO_REG 1.
module tb_regfile_multiport;

  localparam int DW = 12;
  localparam int AW = 3;
`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(2)) ifa ();
  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(2)) ifb ();

  regfile_multiport #(
    .DATA_W(DW), .DEPTH(8), .ADDR_W(AW), .N_READ(2), .ZERO_REG(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  regfile_multiport #(
    .DATA_W(DW), .DEPTH(6), .ADDR_W(AW), .N_READ(2), .ZERO_REG(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    string         tag;
    int            d;
    int            p;
    logic [DW-1:0] data;
    logic          chk;
    logic          valid;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string tag, input int d, input int p,
                      input logic [DW-1:0] data, input logic chk,
                      input logic valid);
    exp_t e;
    e.tag = tag; e.d = d; e.p = p;
    e.data = data; e.chk = chk; e.valid = valid;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    logic [DW-1:0] ad;
    logic av;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ad = (e.d != 0) ? ifb.rdata[e.p*DW +: DW] : ifa.rdata[e.p*DW +: DW];
      av = (e.d != 0) ? ifb.rd_valid[e.p] : ifa.rd_valid[e.p];
      checks++;
      assert (av === e.valid) else begin
        errors++;
        $error("FAIL %s.valid: observed %b expected %b", e.tag, av, e.valid);
      end
      if (e.chk) begin
        checks++;
        assert (ad === e.data) else begin
          errors++;
          $error("FAIL %s.data: observed %h expected %h", e.tag, ad, e.data);
        end
      end
    end
  endtask

  task automatic idle();
    ifa.we = 1'b0; ifa.rd_en = '0;
    ifb.we = 1'b0; ifb.rd_en = '0;
  endtask

  task automatic wr(input int d, input int a, input logic [DW-1:0] v);
    if (d != 0) begin
      ifb.we = 1'b1; ifb.waddr = AW'(a); ifb.wdata = v;
    end else begin
      ifa.we = 1'b1; ifa.waddr = AW'(a); ifa.wdata = v;
    end
  endtask

  task automatic rd(input int d, input int p, input int a);
    if (d != 0) begin
      ifb.rd_en[p] = 1'b1; ifb.raddr[p*AW +: AW] = AW'(a);
    end else begin
      ifa.rd_en[p] = 1'b1; ifa.raddr[p*AW +: AW] = AW'(a);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.waddr = '0; ifa.wdata = '0; ifa.raddr = '0;
    ifb.waddr = '0; ifb.wdata = '0; ifb.raddr = '0;
    idle();

    // reset state, with a read and write request ignored
    rd(0, 0, 0); rd(0, 1, 0); wr(0, 2, 12'h123);
    push("rst_a0", 0, 0, 12'h000, 1'b1, 1'b0);
    push("rst_a1", 0, 1, 12'h000, 1'b1, 1'b0);
    push("rst_b0", 1, 0, 12'h000, 1'b1, 1'b0);
    push("rst_b1", 1, 1, 12'h000, 1'b1, 1'b0);
    cyc();
    rst = 1'b0;
    idle();

    // preload 30,40,...,100
    for (int i = 0; i < 8; i++) begin
      wr(0, i, DW'(30 + 10 * i));
      cyc();
    end
    idle();

    // handshake pulse and hold
    rd(0, 0, 1);
    push("hs_pulse", 0, 0, 12'd40, 1'b1, 1'b1);
    push("hs_p1_idle", 0, 1, 12'd0, 1'b0, 1'b0);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      push("hs_hold", 0, 0, 12'd40, 1'b1, 1'b0);
      cyc();
    end

    // read just before reset still completes
    rd(0, 0, 7); rd(0, 1, 3);
    push("pre_rst0", 0, 0, 12'd100, 1'b1, 1'b1);
    push("pre_rst1", 0, 1, 12'd60, 1'b1, 1'b1);
    cyc();
    idle();

    // reset with a concurrent read: no valid
    rst = 1'b1;
    rd(0, 0, 1); rd(0, 1, 2); wr(0, 4, 12'h7FF);
    push("rst_cyc0", 0, 0, 12'd0, 1'b1, 1'b0);
    push("rst_cyc1", 0, 1, 12'd0, 1'b1, 1'b0);
    cyc();
    rst = 1'b0;
    idle();

    // every entry cleared
    for (int i = 0; i < 4; i++) begin
      rd(0, 0, 2 * i); rd(0, 1, 2 * i + 1);
      push("rst_clr0", 0, 0, 12'd0, 1'b1, 1'b1);
      push("rst_clr1", 0, 1, 12'd0, 1'b1, 1'b1);
      cyc();
      idle();
    end

    // basic write then dual read
    wr(0, 5, 12'h5C0); cyc();
    wr(0, 6, 12'h3C0); cyc();
    idle();
    rd(0, 0, 5); rd(0, 1, 6);
    push("basic0", 0, 0, 12'h5C0, 1'b1, 1'b1);
    push("basic1", 0, 1, 12'h3C0, 1'b1, 1'b1);
    cyc();
    idle();

    // same-cycle collision
    wr(0, 3, 12'h111); cyc();
    wr(0, 3, 12'h222); rd(0, 0, 3);
    push("coll", 0, 0, BYP ? 12'h222 : 12'h111, 1'b1, 1'b1);
    cyc();
    idle();
    rd(0, 0, 3);
    push("coll_next", 0, 0, 12'h222, 1'b1, 1'b1);
    cyc();
    idle();

    // collision on port1 while port0 reads another entry
    wr(0, 6, 12'h0AB); rd(0, 0, 5); rd(0, 1, 6);
    push("coll_p0", 0, 0, 12'h5C0, 1'b1, 1'b1);
    push("coll_p1", 0, 1, BYP ? 12'h0AB : 12'h3C0, 1'b1, 1'b1);
    cyc();
    idle();

    // zero register
    wr(1, 0, 12'hFFF); cyc();
    idle();
    rd(1, 0, 0); rd(1, 1, 0);
    push("zero0", 1, 0, 12'h000, 1'b1, 1'b1);
    push("zero1", 1, 1, 12'h000, 1'b1, 1'b1);
    cyc();
    idle();
    wr(1, 0, 12'h7AA); rd(1, 0, 0);
    push("zero_coll", 1, 0, 12'h000, 1'b1, 1'b1);
    cyc();
    idle();

    // out of range on DEPTH 6
    wr(1, 5, 12'h155); cyc();
    wr(1, 7, 12'hABC); cyc();
    idle();
    rd(1, 0, 7); rd(1, 1, 5);
    push("oor7", 1, 0, 12'h000, 1'b1, 1'b1);
    push("keep5", 1, 1, 12'h155, 1'b1, 1'b1);
    cyc();
    idle();
    wr(1, 6, 12'h666); rd(1, 0, 6);
    push("oor_coll", 1, 0, 12'h000, 1'b1, 1'b1);
    cyc();
    idle();

    // in-range collision on dut_b
    wr(1, 4, 12'h444); rd(1, 1, 4);
    push("b_coll", 1, 1, BYP ? 12'h444 : 12'h000, 1'b1, 1'b1);
    cyc();
    idle();
    rd(1, 1, 4);
    push("b_next", 1, 1, 12'h444, 1'b1, 1'b1);
    cyc();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
